// File: rtl/seven_seg_scan_ctrl.sv
// Scan controller for a multi-digit common-anode 7-segment display sharing one code decoder.
// Optional leading-zero blanking is enabled by defining SEVEN_SEG_LZB_EN.
module seven_seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [3*NUM_DIGITS-1:0]   digit_data,
   input  logic [NUM_DIGITS-1:0]     digit_en,
   input  logic                      load,
   output logic [2:0]                cntr,
   output logic [NUM_DIGITS-1:0]     anode,
   output logic                      frame_start,
   output logic                      busy_update
);

   localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int IDX_W   = $clog2(NUM_DIGITS);

   localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] ALL_OFF = {NUM_DIGITS{1'b1}};

   typedef enum logic {
      GAP  = 1'b0,
      SHOW = 1'b1
   } state_t;

   state_t                    state, state_nxt;
   logic [CNT_W-1:0]          cnt, cnt_nxt;
   logic [IDX_W-1:0]          idx, idx_nxt;
   logic [2:0]                cntr_nxt;
   logic [NUM_DIGITS-1:0]     anode_nxt;
   logic                      fs_nxt, busy_nxt, enter_show;
   logic [3*NUM_DIGITS-1:0]   shadow_code, shadow_code_nxt, pend_code, pend_code_nxt;
   logic [NUM_DIGITS-1:0]     shadow_en, shadow_en_nxt, pend_en, pend_en_nxt;
   logic [NUM_DIGITS-1:0]     lit;

`ifdef SEVEN_SEG_LZB_EN
   // A zero digit stays dark while every enabled digit above it is also zero.
   function automatic logic [NUM_DIGITS-1:0] lzb_mask(input logic [3*NUM_DIGITS-1:0] codes,
                                                       input logic [NUM_DIGITS-1:0]   en);
      logic                  seen;
      logic [NUM_DIGITS-1:0] m;
      seen = 1'b0;
      m    = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         if (en[i] && (codes[3*i +: 3] != 3'd0))
            seen = 1'b1;
         m[i] = en[i] && (seen || (i == 0));
      end
      return m;
   endfunction
`endif

   always_comb begin
      state_nxt       = state;
      cnt_nxt         = cnt + 1'b1;
      idx_nxt         = idx;
      cntr_nxt        = cntr;
      anode_nxt       = ALL_OFF;
      fs_nxt          = 1'b0;
      busy_nxt        = busy_update;
      shadow_code_nxt = shadow_code;
      shadow_en_nxt   = shadow_en;
      pend_code_nxt   = pend_code;
      pend_en_nxt     = pend_en;
      enter_show      = 1'b0;
      lit             = '0;

      case (state)
         GAP: begin
            if ((BLANK_CYCLES == 0) || (cnt == GAP_LAST))
               enter_show = 1'b1;
         end
         SHOW: begin
            if (cnt == SHOW_LAST) begin
               if (BLANK_CYCLES == 0) begin
                  enter_show = 1'b1;
               end else begin
                  state_nxt = GAP;
                  cnt_nxt   = '0;
               end
            end
         end
         default: begin
            state_nxt = GAP;
            cnt_nxt   = '0;
         end
      endcase

      if (enter_show) begin
         state_nxt = SHOW;
         cnt_nxt   = '0;
         idx_nxt   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
         // Frame boundary: swap in new data so it shows in this very slot.
         if (idx == IDX_LAST) begin
            fs_nxt = 1'b1;
            if (load || busy_update) begin
               shadow_code_nxt = load ? digit_data : pend_code;
               shadow_en_nxt   = load ? digit_en   : pend_en;
               busy_nxt        = 1'b0;
            end
         end
      end

      if (load && !fs_nxt) begin
         pend_code_nxt = digit_data;
         pend_en_nxt   = digit_en;
         busy_nxt      = 1'b1;
      end

`ifdef SEVEN_SEG_LZB_EN
      lit = lzb_mask(shadow_code_nxt, shadow_en_nxt);
`else
      lit = shadow_en_nxt;
`endif

      // A disabled digit still consumes its slot, keeping duty constant.
      if (state_nxt == SHOW) begin
         if (lit[idx_nxt])
            anode_nxt[idx_nxt] = 1'b0;
         cntr_nxt = shadow_code_nxt[3*idx_nxt +: 3];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= GAP;
         cnt         <= '0;
         idx         <= IDX_LAST;
         cntr        <= 3'd0;
         anode       <= ALL_OFF;
         frame_start <= 1'b0;
         busy_update <= 1'b0;
         shadow_code <= '0;
         shadow_en   <= '0;
         pend_code   <= '0;
         pend_en     <= '0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         idx         <= idx_nxt;
         cntr        <= cntr_nxt;
         anode       <= anode_nxt;
         frame_start <= fs_nxt;
         busy_update <= busy_nxt;
         shadow_code <= shadow_code_nxt;
         shadow_en   <= shadow_en_nxt;
         pend_code   <= pend_code_nxt;
         pend_en     <= pend_en_nxt;
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl: one instance with a 1-cycle gap, one with no gap.
module tb_seven_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, rst0_n;
   logic [11:0] dd;
   logic [3:0]  de;
   logic        ld, ld0;
   logic [2:0]  cntr1, cntr0;
   logic [3:0]  an1, an0;
   logic        fs1, fs0, bu1, bu0;

   logic        sel;
   logic [2:0]  c_cntr;
   logic [3:0]  c_anode;
   logic        c_fs, c_bu;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   seven_seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
      .clk(clk), .rst_n(rst_n), .digit_data(dd), .digit_en(de), .load(ld),
      .cntr(cntr1), .anode(an1), .frame_start(fs1), .busy_update(bu1)
   );

   seven_seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(0)) dut_nb (
      .clk(clk), .rst_n(rst0_n), .digit_data(dd), .digit_en(de), .load(ld0),
      .cntr(cntr0), .anode(an0), .frame_start(fs0), .busy_update(bu0)
   );

   assign c_cntr  = sel ? cntr0 : cntr1;
   assign c_anode = sel ? an0   : an1;
   assign c_fs    = sel ? fs0   : fs1;
   assign c_bu    = sel ? bu0   : bu1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic wait_fs();
      int n = 0;
      while (c_fs !== 1'b1 && n < 64) begin
         @(negedge clk);
         n++;
      end
      chk("fs_wait", c_fs, 1);
   endtask

   // Called on the frame_start cycle; ends on the following frame_start cycle.
   task automatic check_frame(input int gap, input logic [11:0] codes, input logic [15:0] ans);
      int len = 4 + gap;
      int slot, pos;
      for (int j = 0; j < 4 * len; j++) begin
         slot = j / len;
         pos  = j % len;
         chk("frame_fs", c_fs, (j == 0));
         if (pos < 4) chk("slot_anode", c_anode, ans[4*slot +: 4]);
         else         chk("gap_anode", c_anode, 4'hF);
         chk("slot_cntr", c_cntr, codes[3*slot +: 3]);
         chk("single_low", ($countones(~c_anode) <= 1), 1);
         @(negedge clk);
      end
      chk("period_fs", c_fs, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; rst0_n = 1'b0;
      ld = 1'b0; ld0 = 1'b0; dd = '0; de = '0; sel = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_anode", c_anode, 4'hF);
      chk("rst_cntr", c_cntr, 0);
      chk("rst_fs", c_fs, 0);
      chk("rst_busy", c_bu, 0);

      // Idle after release: dark display, frame_start at 1, 21, 41.
      rst_n = 1'b1;
      for (int k = 1; k <= 41; k++) begin
         @(negedge clk);
         chk("idle_anode", c_anode, 4'hF);
         chk("idle_fs", c_fs, (k == 1 || k == 21 || k == 41));
      end

      // Mid-frame load of 3210, all enabled.
      repeat (2) @(negedge clk);
      dd = 12'o3210; de = 4'hF; ld = 1'b1;
      @(negedge clk);
      ld = 1'b0;
      chk("busy_set", c_bu, 1);
      @(negedge clk);
      chk("busy_hold", c_bu, 1);
      wait_fs();
      chk("busy_clr", c_bu, 0);
      check_frame(1, 12'o3210, {4'b0111, 4'b1011, 4'b1101, 4'b1110});

      // Two loads in one frame: last one wins.
      @(negedge clk);
      dd = 12'o1111; ld = 1'b1;
      @(negedge clk);
      ld = 1'b0;
      repeat (3) @(negedge clk);
      dd = 12'o7777; ld = 1'b1;
      @(negedge clk);
      ld = 1'b0;
      wait_fs();
      check_frame(1, 12'o7777, {4'b0111, 4'b1011, 4'b1101, 4'b1110});

      // Load sampled by the boundary edge goes straight to the display.
      repeat (19) @(negedge clk);
      dd = 12'o5555; ld = 1'b1;
      @(negedge clk);
      ld = 1'b0;
      chk("bnd_fs", c_fs, 1);
      chk("bnd_cntr", c_cntr, 5);
      chk("bnd_busy", c_bu, 0);
      check_frame(1, 12'o5555, {4'b0111, 4'b1011, 4'b1101, 4'b1110});
      chk("bnd_busy_after", c_bu, 0);

      // Partial enables: only slots 0 and 2 light.
      @(negedge clk);
      dd = 12'o4321; de = 4'b0101; ld = 1'b1;
      @(negedge clk);
      ld = 1'b0;
      wait_fs();
      check_frame(1, 12'o4321, {4'hF, 4'b1011, 4'hF, 4'b1110});

      // Leading zeros.
      @(negedge clk);
      dd = 12'o0030; de = 4'hF; ld = 1'b1;
      @(negedge clk);
      ld = 1'b0;
      wait_fs();
`ifdef SEVEN_SEG_LZB_EN
      check_frame(1, 12'o0030, {4'hF, 4'hF, 4'b1101, 4'b1110});
`else
      check_frame(1, 12'o0030, {4'b0111, 4'b1011, 4'b1101, 4'b1110});
`endif

      // Asynchronous reset in the middle of a lit slot, with pending data.
      @(negedge clk);
      dd = 12'o7777; de = 4'hF; ld = 1'b1;
      @(negedge clk);
      ld = 1'b0;
      chk("pre_rst_busy", c_bu, 1);
      chk("pre_rst_anode", c_anode, 4'b1110);
      #2 rst_n = 1'b0;
      #1;
      chk("async_anode", c_anode, 4'hF);
      chk("async_cntr", c_cntr, 0);
      chk("async_busy", c_bu, 0);
      chk("async_fs", c_fs, 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_fs();
      check_frame(1, 12'o0000, {4'hF, 4'hF, 4'hF, 4'hF});

      // No-gap instance.
      sel = 1'b1;
      de = 4'h0; dd = '0;
      @(negedge clk);
      rst0_n = 1'b1;
      @(negedge clk);
      chk("nb_first_fs", c_fs, 1);
      chk("nb_first_anode", c_anode, 4'hF);
      repeat (2) @(negedge clk);
      dd = 12'o4321; de = 4'b0101; ld0 = 1'b1;
      @(negedge clk);
      ld0 = 1'b0;
      wait_fs();
      check_frame(0, 12'o4321, {4'hF, 4'b1011, 4'hF, 4'b1110});
      @(negedge clk);
      dd = 12'o3210; de = 4'hF; ld0 = 1'b1;
      @(negedge clk);
      ld0 = 1'b0;
      wait_fs();
      check_frame(0, 12'o3210, {4'b0111, 4'b1011, 4'b1101, 4'b1110});

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
